// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU control codes and controller state encoding for alu_share_ctrl.
// ALU_SHARE_MUL_STALL_EN adds the MUL_WAIT state.
package alu_share_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
`ifdef ALU_SHARE_MUL_STALL_EN
        ST_MUL_WAIT = 2'd2,
`endif
        ST_RESP     = 2'd3
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a sole requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant,
    output logic       gnt_id
);

    assign grant  = |valid;
    assign gnt_id = (&valid) ? ~last_grant : valid[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin grant.
// Define ALU_SHARE_MUL_STALL_EN to hold the ALU for MUL_LAT cycles on MUL.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CTRL_W  = 3,
    parameter int MUL_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [WIDTH-1:0]  req0_data1_i,
    input  logic [WIDTH-1:0]  req0_data2_i,
    input  logic [CTRL_W-1:0] req0_ctrl_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [WIDTH-1:0]  req1_data1_i,
    input  logic [WIDTH-1:0]  req1_data2_i,
    input  logic [CTRL_W-1:0] req1_ctrl_i,
    output logic [WIDTH-1:0]  alu_data1_o,
    output logic [WIDTH-1:0]  alu_data2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [WIDTH-1:0]  alu_data_i,
    input  logic              alu_zero_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_id_o,
    output logic [WIDTH-1:0]  rsp_data_o,
    output logic              rsp_zero_o
);

    // state    | meaning
    // IDLE     | grant one valid requester, latch its operation
    // EXEC     | ALU evaluates latched operands, result captured
    // MUL_WAIT | multi-cycle MUL in progress (stall build only)
    // RESP     | result held until the consumer takes it

    if (MUL_LAT < 2) begin : g_mul_lat_check
        $error("alu_share_ctrl: MUL_LAT must be at least 2");
    end

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              op_id_q;
    logic              arb_grant, arb_id;
    logic              accept, capture;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_zero_q, rsp_id_q;

`ifdef ALU_SHARE_MUL_STALL_EN
    localparam int CNT_W = $clog2(MUL_LAT);
    logic [CNT_W-1:0]  mul_cnt_q;
    logic              mul_start;
`endif

    rr_arb2 u_arb (
        .valid      ({req1_valid_i, req0_valid_i}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .gnt_id     (arb_id)
    );

    // Ready is also held low while reset is asserted so nothing looks accepted.
    assign req0_ready_o = rst_i & (state_q == ST_IDLE) & arb_grant & ~arb_id;
    assign req1_ready_o = rst_i & (state_q == ST_IDLE) & arb_grant &  arb_id;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
`ifdef ALU_SHARE_MUL_STALL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_grant) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef ALU_SHARE_MUL_STALL_EN
                if (alu_ctrl_o == CTRL_W'(ALU_MUL)) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL_WAIT;
                end else begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
`else
                capture = 1'b1;
                state_d = ST_RESP;
`endif
            end
`ifdef ALU_SHARE_MUL_STALL_EN
            ST_MUL_WAIT: begin
                if (mul_cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_id_q      <= 1'b0;
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_ctrl_o   <= '0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= arb_id;
                op_id_q      <= arb_id;
                alu_data1_o  <= arb_id ? req1_data1_i : req0_data1_i;
                alu_data2_o  <= arb_id ? req1_data2_i : req0_data2_i;
                alu_ctrl_o   <= arb_id ? req1_ctrl_i  : req0_ctrl_i;
            end
            if (capture) begin
                rsp_data_q <= alu_data_i;
                rsp_zero_q <= alu_zero_i;
                rsp_id_q   <= op_id_q;
            end
        end
    end

`ifdef ALU_SHARE_MUL_STALL_EN
    // Loaded with MUL_LAT-2 so MUL_WAIT lasts MUL_LAT-1 cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mul_cnt_q <= '0;
        end else if (mul_start) begin
            mul_cnt_q <= CNT_W'(MUL_LAT - 2);
        end else if (state_q == ST_MUL_WAIT && mul_cnt_q != '0) begin
            mul_cnt_q <= mul_cnt_q - CNT_W'(1);
        end
    end
`endif

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a behavioural ALU.
// Expects MUL latency of 4 cycles when ALU_SHARE_MUL_STALL_EN is defined, else 2.
module tb_alu_share_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o;
    logic [31:0] req0_data1_i, req0_data2_i;
    logic [2:0]  req0_ctrl_i;
    logic        req1_valid_i, req1_ready_o;
    logic [31:0] req1_data1_i, req1_data2_i;
    logic [2:0]  req1_ctrl_i;
    logic [31:0] alu_data1_o, alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o;
    logic [31:0] rsp_data_o;

    int n_asserts = 0;
    int n_fail    = 0;
    int lat;

`ifdef ALU_SHARE_MUL_STALL_EN
    localparam int MUL_EXP_LAT = 4;
`else
    localparam int MUL_EXP_LAT = 2;
`endif

    always #5 clk_i = ~clk_i;

    alu_share_ctrl #(.WIDTH(32), .CTRL_W(3), .MUL_LAT(3)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_data1_i (req0_data1_i),
        .req0_data2_i (req0_data2_i),
        .req0_ctrl_i  (req0_ctrl_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_data1_i (req1_data1_i),
        .req1_data2_i (req1_data2_i),
        .req1_ctrl_i  (req1_ctrl_i),
        .alu_data1_o  (alu_data1_o),
        .alu_data2_o  (alu_data2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_data_i   (alu_data_i),
        .alu_zero_i   (alu_zero_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_zero_o   (rsp_zero_o)
    );

    // Reference ALU; unused codes return 0.
    always_comb begin
        alu_data_i = 32'd0;
        case (alu_ctrl_o)
            3'b000:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b001:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b100:  alu_data_i = alu_data1_o * alu_data2_o;
            3'b110:  alu_data_i = alu_data1_o - alu_data2_o;
            default: alu_data_i = 32'd0;
        endcase
    end
    assign alu_zero_i = (alu_data_i == 32'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        req0_valid_i = 1'b0; req0_data1_i = '0; req0_data2_i = '0; req0_ctrl_i = '0;
        req1_valid_i = 1'b0; req1_data1_i = '0; req1_data2_i = '0; req1_ctrl_i = '0;

        // reset state
        mid();
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_data",  rsp_data_o,  0);
        chk("rst_alu_ctrl",  alu_ctrl_o,  0);
        tick();
        rst_i = 1'b1;

        // single op: req0 ADD 5,7
        req0_valid_i = 1'b1; req0_data1_i = 32'd5; req0_data2_i = 32'd7; req0_ctrl_i = 3'b010;
        mid();
        chk("single_r0_ready", req0_ready_o, 1);
        chk("single_r1_ready", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0;
        mid();
        chk("single_exec_valid", rsp_valid_o, 0);
        chk("single_alu_d1",     alu_data1_o, 5);
        chk("single_alu_ctrl",   alu_ctrl_o,  3'b010);
        tick();
        mid();
        chk("single_rsp_valid", rsp_valid_o, 1);
        chk("single_rsp_data",  rsp_data_o,  12);
        chk("single_rsp_zero",  rsp_zero_o,  0);
        chk("single_rsp_id",    rsp_id_o,    0);
        tick();
        mid();
        chk("single_idle_valid", rsp_valid_o, 0);

        // reset mid-EXEC of a req0 op (req0 granted last before reset)
        tick();
        req0_valid_i = 1'b1; req0_data1_i = 32'd3; req0_data2_i = 32'd4; req0_ctrl_i = 3'b010;
        tick();
        req0_valid_i = 1'b0;
        mid();
        chk("rst2_inflight_d1", alu_data1_o, 3);
        #1;
        rst_i = 1'b0;
        req0_valid_i = 1'b1; req0_data1_i = 32'hF0; req0_data2_i = 32'h0F; req0_ctrl_i = 3'b000;
        req1_valid_i = 1'b1; req1_data1_i = 32'd9;  req1_data2_i = 32'd4;  req1_ctrl_i = 3'b110;
        #2;
        chk("rst2_rsp_valid", rsp_valid_o,  0);
        chk("rst2_alu_d1",    alu_data1_o,  0);
        chk("rst2_alu_ctrl",  alu_ctrl_o,   0);
        chk("rst2_r0_ready",  req0_ready_o, 0);
        chk("rst2_r1_ready",  req1_ready_o, 0);
        chk("rst2_rsp_data",  rsp_data_o,   0);
        tick();
        rst_i = 1'b1;

        // tie: req0 first after reset
        mid();
        chk("tie1_r0_ready", req0_ready_o, 1);
        chk("tie1_r1_ready", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0;
        mid();
        chk("tie1_exec_r1_ready", req1_ready_o, 0);
        tick();
        mid();
        chk("tie1_rsp_data", rsp_data_o, 0);
        chk("tie1_rsp_zero", rsp_zero_o, 1);
        chk("tie1_rsp_id",   rsp_id_o,   0);
        tick();
        mid();
        chk("tie1_r1_ready_idle", req1_ready_o, 1);
        tick();
        req1_valid_i = 1'b0;
        mid();
        tick();
        mid();
        chk("tie2_rsp_valid", rsp_valid_o, 1);
        chk("tie2_rsp_data",  rsp_data_o,  5);
        chk("tie2_rsp_zero",  rsp_zero_o,  0);
        chk("tie2_rsp_id",    rsp_id_o,    1);
        tick();

        // repeated tie alternates back to req0; then backpressure
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        rsp_ready_i  = 1'b0;
        mid();
        chk("tie3_r0_ready", req0_ready_o, 1);
        chk("tie3_r1_ready", req1_ready_o, 0);
        tick();
        req0_valid_i = 1'b0;
        mid();
        for (int i = 0; i < 4; i++) begin
            tick();
            mid();
            chk("bp_rsp_valid", rsp_valid_o,  1);
            chk("bp_rsp_data",  rsp_data_o,   0);
            chk("bp_rsp_id",    rsp_id_o,     0);
            chk("bp_rsp_zero",  rsp_zero_o,   1);
            chk("bp_r1_ready",  req1_ready_o, 0);
        end
        tick();
        rsp_ready_i = 1'b1;
        mid();
        chk("bp_release_valid", rsp_valid_o, 1);
        tick();
        mid();
        chk("bp_after_r1_ready", req1_ready_o, 1);
        tick();
        req1_valid_i = 1'b0;
        mid();
        tick();
        mid();
        chk("bp_r1_rsp_data", rsp_data_o, 5);
        chk("bp_r1_rsp_id",   rsp_id_o,   1);
        tick();

        // MUL 6,7 latency
        req0_valid_i = 1'b1; req0_data1_i = 32'd6; req0_data2_i = 32'd7; req0_ctrl_i = 3'b100;
        mid();
        chk("mul_r0_ready", req0_ready_o, 1);
        tick();
        req0_valid_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            mid();
            if (rsp_valid_o) begin
                lat = i;
                break;
            end
            chk("mul_hold_d1", alu_data1_o, 6);
            tick();
        end
        chk("mul_latency",  lat,        MUL_EXP_LAT);
        chk("mul_rsp_data", rsp_data_o, 42);
        tick();

        // req1 raises then withdraws valid while req0 op is in flight
        req0_valid_i = 1'b1; req0_data1_i = 32'd1; req0_data2_i = 32'd1; req0_ctrl_i = 3'b111;
        mid();
        chk("wd_r0_ready", req0_ready_o, 1);
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1; req1_data1_i = 32'd9; req1_data2_i = 32'd4; req1_ctrl_i = 3'b110;
        mid();
        chk("wd_exec_r1_ready", req1_ready_o, 0);
        chk("wd_ctrl_passthru", alu_ctrl_o,   3'b111);
        tick();
        mid();
        chk("wd_rsp_valid",    rsp_valid_o,  1);
        chk("wd_rsp_id",       rsp_id_o,     0);
        chk("wd_rsp_data",     rsp_data_o,   0);
        chk("wd_rsp_r1_ready", req1_ready_o, 0);
        req1_valid_i = 1'b0;
        tick();
        mid();
        chk("wd_idle_r0_ready", req0_ready_o, 0);
        chk("wd_idle_r1_ready", req1_ready_o, 0);
        chk("wd_idle_valid",    rsp_valid_o,  0);
        tick();
        req0_valid_i = 1'b1; req0_data1_i = 32'd5; req0_data2_i = 32'd7; req0_ctrl_i = 3'b010;
        req1_valid_i = 1'b1;
        mid();
        chk("wd_tie_r1_ready", req1_ready_o, 1);
        chk("wd_tie_r0_ready", req0_ready_o, 0);
        tick();
        req1_valid_i = 1'b0;
        mid();
        tick();
        mid();
        chk("wd_r1_rsp_data", rsp_data_o, 5);
        chk("wd_r1_rsp_id",   rsp_id_o,   1);
        tick();
        mid();
        chk("wd_final_r0_ready", req0_ready_o, 1);
        tick();
        req0_valid_i = 1'b0;
        mid();
        tick();
        mid();
        chk("wd_final_rsp_data", rsp_data_o, 12);
        chk("wd_final_rsp_id",   rsp_id_o,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
